io_host_master: RTL

- Bus initiator that drives the IO_Handler register port: io_addr, io_write, io_read and io_wdata, with io_rdata and io_irq returned.
- Converts a valid/ready command stream from the host side into single-cycle register accesses.
- Returns read data on a valid/ready response stream.
- Services io_irq on its own by reading STATUS and then DATA_IN.

---
 rtl/io_host_pkg.sv | 33 +++
 rtl/io_host_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_host_pkg.sv
// ============================================================================
// Module      : io_host_pkg
// Description : Shared register map and state encodings for io_host_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_host_pkg;

    localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
    localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
    localparam logic [1:0] ADDR_CONTROL  = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WR          = 3'd1,
        ST_RD          = 3'd2,
        ST_RD_WAIT     = 3'd3,
        ST_RSP         = 3'd4,
        ST_IRQ_RD_STAT = 3'd5,
        ST_IRQ_RD_DATA = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SVC_NONE   = 2'd0,
        SVC_STATUS = 2'd1,
        SVC_DATA   = 2'd2
    } svc_phase_e;

endpackage

`default_nettype wire

// File: rtl/io_host_master.sv
// ============================================================================
// Module      : io_host_master
// Description : Command/response bridge onto the IO_Handler register port,
//               with autonomous STATUS-then-DATA_IN interrupt service.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_host_master
    import io_host_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [1:0]       cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_addr,
    output logic             rsp_irq,
    input  logic             irq_auto_en,
    output logic [1:0]       io_addr,
    output logic             io_write,
    output logic             io_read,
    output logic [WIDTH-1:0] io_wdata,
    input  logic [WIDTH-1:0] io_rdata,
    input  logic             io_irq,
    output logic             busy,
    output logic [7:0]       irq_miss_cnt
);

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_e           state_q, state_d;
    svc_phase_e       svc_q, svc_d;
    logic [1:0]       addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_addr_q, rsp_addr_d;
    logic             rsp_irq_q, rsp_irq_d;
    logic             irq_q;
    logic             irq_pending_q, irq_pending_d;
    logic [7:0]       miss_q, miss_d;
    logic             svc_take;
    logic             irq_accept;

    // An edge that arrives while one is still pending is lost, even if the
    // pending one is being taken into service in the same cycle.
    always_comb begin
        irq_accept    = io_irq && !irq_q && irq_auto_en;
        irq_pending_d = svc_take ? 1'b0 : (irq_pending_q || irq_accept);
        miss_d        = miss_q;
        if (irq_accept && irq_pending_q && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        svc_d      = svc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_irq_d  = rsp_irq_q;
        svc_take   = 1'b0;
        cmd_ready  = 1'b0;
        io_write   = 1'b0;
        io_read    = 1'b0;
        io_addr    = '0;
        io_wdata   = '0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = !irq_pending_q && !reset;
                if (irq_pending_q) begin
                    svc_take = 1'b1;
                    svc_d    = SVC_STATUS;
                    addr_d   = ADDR_STATUS;
                    state_d  = ST_IRQ_RD_STAT;
                end else if (cmd_valid && cmd_ready) begin
                    svc_d   = SVC_NONE;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                io_write = 1'b1;
                io_addr  = addr_q;
                io_wdata = wdata_q;
                state_d  = ST_IDLE;
            end
            ST_RD, ST_IRQ_RD_STAT, ST_IRQ_RD_DATA: begin
                io_read = 1'b1;
                io_addr = addr_q;
                cnt_d   = 2'd0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rsp_data_d = io_rdata;
                    rsp_addr_d = addr_q;
                    rsp_irq_d  = (svc_q != SVC_NONE);
                    state_d    = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (svc_q == SVC_STATUS) begin
                        svc_d   = SVC_DATA;
                        addr_d  = ADDR_DATA_IN;
                        state_d = ST_IRQ_RD_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            svc_q         <= SVC_NONE;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            rsp_irq_q     <= 1'b0;
            irq_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            svc_q         <= svc_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_irq_q     <= rsp_irq_d;
            irq_q         <= io_irq;
            irq_pending_q <= irq_pending_d;
            miss_q        <= miss_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RSP);
    assign rsp_data     = rsp_data_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_irq      = rsp_irq_q;
    assign busy         = (state_q != ST_IDLE);
    assign irq_miss_cnt = miss_q;

endmodule

`default_nettype wire
